// File: rtl/qubit_measure_sampler.sv
// Turns free-running PRNG words into a valid/ready stream of Bernoulli outcomes.
// Optional QMEAS_TALLY_EN keeps a per-run count of accepted ones.
module qubit_measure_sampler #(
    parameter int PROB_W = 16,
    parameter int SHOT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       rand_word,
    input  logic              start,
    input  logic [PROB_W:0]   prob_one,
    input  logic [SHOT_W-1:0] shots,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              busy,
    output logic              done,
    output logic [SHOT_W-1:0] ones_count
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    state_t            state_nx;
    logic [PROB_W:0]   prob_reg;
    logic [SHOT_W-1:0] issue_left;
    logic [SHOT_W-1:0] accept_left;
    logic              sample;
    logic              accept;
    logic              load;
    logic              xfer;
    logic              last_xfer;
    logic              unused_rand;

    // One extra bit on the compare lets prob == 1.0 always win.
    assign sample    = {1'b0, rand_word[31 -: PROB_W]} < prob_reg;
    assign accept    = (state == IDLE) && start;
    assign xfer      = out_valid && out_ready;
    assign load      = (state == RUN) && (!out_valid || out_ready)
                       && (issue_left != '0);
    assign last_xfer = xfer && (accept_left == SHOT_W'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    assign unused_rand = ^rand_word[31-PROB_W:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (accept_left == '0 || last_xfer) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prob_reg    <= '0;
            issue_left  <= '0;
            accept_left <= '0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
        end else if (accept) begin
            prob_reg    <= prob_one;
            issue_left  <= shots;
            accept_left <= shots;
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_bit    <= sample;
                issue_left <= issue_left - SHOT_W'(1);
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_bit   <= 1'b0;
            end
            if (xfer) begin
                accept_left <= accept_left - SHOT_W'(1);
            end
        end
    end

`ifdef QMEAS_TALLY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones_count <= '0;
        end else if (accept) begin
            ones_count <= '0;
        end else if (xfer && out_bit && (ones_count != '1)) begin
            ones_count <= ones_count + SHOT_W'(1);
        end
    end
`else
    assign ones_count = '0;
`endif

endmodule

// File: tb/tb_qubit_measure_sampler.sv
// Directed bench for qubit_measure_sampler: thresholds, backpressure,
// zero-shot runs, ignored restarts and mid-run reset.
module tb_qubit_measure_sampler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rand_word = 32'h1234_5678;
    logic        rand_hold = 1'b0;
    logic [31:0] rand_fixed = 32'h0;
    logic        start = 1'b0;
    logic [16:0] prob_one = '0;
    logic [15:0] shots = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_bit;
    logic        busy;
    logic        done;
    logic [15:0] ones_count;

    int vectors = 0;
    int miscompares = 0;

    qubit_measure_sampler dut (
        .clk(clk),
        .reset_n(reset_n),
        .rand_word(rand_word),
        .start(start),
        .prob_one(prob_one),
        .shots(shots),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit(out_bit),
        .busy(busy),
        .done(done),
        .ones_count(ones_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        rand_word <= rand_hold ? rand_fixed
                   : rand_word * 32'd1103515245 + 32'd12345;

    function automatic int exp_tally(input int n);
`ifdef QMEAS_TALLY_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Called at a negedge; returns at the negedge of the cycle after edge N.
    task automatic do_start(input logic [16:0] p, input logic [15:0] s);
        start = 1'b1;
        prob_one = p;
        shots = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples at each negedge; optional one-cycle start poke at index poke.
    task automatic observe(input int cycles, input int poke,
                           output int nxfer, output int nones,
                           output int first, output int done_at,
                           output int ndone);
        nxfer = 0; nones = 0; first = -1; done_at = -1; ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid && out_ready) begin
                nxfer++;
                if (out_bit) nones++;
                if (first < 0) first = i;
            end
            if (done) begin
                ndone++;
                done_at = i;
            end
            if (i == poke) begin
                start = 1'b1; prob_one = 17'h0; shots = 16'd3;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (out_bit !== 1'b0) begin miscompares++; $display("FAIL rst_bit got %b want 0", out_bit); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
        if (ones_count !== 16'd0) begin miscompares++; $display("FAIL rst_ones got %0d want 0", ones_count); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prob_zero;
        int nx, no, fi, da, nd;
        out_ready = 1'b1;
        do_start(17'h0, 16'd8);
        observe(14, -1, nx, no, fi, da, nd);
        vectors += 7;
        if (nx !== 8) begin miscompares++; $display("FAIL p0_xfers got %0d want 8", nx); end
        if (no !== 0) begin miscompares++; $display("FAIL p0_ones got %0d want 0", no); end
        if (fi !== 1) begin miscompares++; $display("FAIL p0_first got %0d want 1", fi); end
        if (da !== 9) begin miscompares++; $display("FAIL p0_done_at got %0d want 9", da); end
        if (nd !== 1) begin miscompares++; $display("FAIL p0_ndone got %0d want 1", nd); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL p0_busy got %b want 0", busy); end
        if (ones_count !== 16'(exp_tally(0))) begin miscompares++; $display("FAIL p0_tally got %0d want %0d", ones_count, exp_tally(0)); end
    endtask

    task automatic test_prob_one;
        int nx, no, fi, da, nd;
        do_start(17'h10000, 16'd8);
        observe(14, -1, nx, no, fi, da, nd);
        vectors += 4;
        if (nx !== 8) begin miscompares++; $display("FAIL p1_xfers got %0d want 8", nx); end
        if (no !== 8) begin miscompares++; $display("FAIL p1_ones got %0d want 8", no); end
        if (da !== 9) begin miscompares++; $display("FAIL p1_done_at got %0d want 9", da); end
        if (ones_count !== 16'(exp_tally(8))) begin miscompares++; $display("FAIL p1_tally got %0d want %0d", ones_count, exp_tally(8)); end
    endtask

    task automatic test_threshold;
        int nx, no, fi, da, nd;
        rand_fixed = 32'h8000_0000;
        rand_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_start(17'h08000, 16'd1);
        observe(5, -1, nx, no, fi, da, nd);
        vectors += 3;
        if (nx !== 1) begin miscompares++; $display("FAIL th_lo_xfers got %0d want 1", nx); end
        if (no !== 0) begin miscompares++; $display("FAIL th_lo_bit got %0d want 0", no); end
        if (da !== 2) begin miscompares++; $display("FAIL th_lo_done_at got %0d want 2", da); end
        do_start(17'h08001, 16'd1);
        observe(5, -1, nx, no, fi, da, nd);
        vectors += 3;
        if (nx !== 1) begin miscompares++; $display("FAIL th_hi_xfers got %0d want 1", nx); end
        if (no !== 1) begin miscompares++; $display("FAIL th_hi_bit got %0d want 1", no); end
        if (ones_count !== 16'(exp_tally(1))) begin miscompares++; $display("FAIL th_hi_tally got %0d want %0d", ones_count, exp_tally(1)); end
        rand_hold = 1'b0;
    endtask

    task automatic test_backpressure;
        int nx, no, fi, da, nd;
        logic hold_bit;
        int stable;
        out_ready = 1'b0;
        do_start(17'h08000, 16'd4);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_early_valid got %b want 0", out_valid); end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_first_valid got %b want 1", out_valid); end
        hold_bit = out_bit;
        stable = 1;
        for (int k = 0; k < 5; k++) begin
            if (!out_valid || out_bit !== hold_bit) stable = 0;
            if (k < 4) @(negedge clk);
        end
        vectors++;
        if (stable !== 1) begin miscompares++; $display("FAIL bp_stable got %0d want 1", stable); end
        out_ready = 1'b1;
        observe(8, -1, nx, no, fi, da, nd);
        vectors += 4;
        if (nx !== 4) begin miscompares++; $display("FAIL bp_xfers got %0d want 4", nx); end
        if (da !== 4) begin miscompares++; $display("FAIL bp_done_at got %0d want 4", da); end
        if (nd !== 1) begin miscompares++; $display("FAIL bp_ndone got %0d want 1", nd); end
        if (ones_count !== 16'(exp_tally(no))) begin miscompares++; $display("FAIL bp_tally got %0d want %0d", ones_count, exp_tally(no)); end
    endtask

    task automatic test_zero_shots;
        int nx, no, fi, da, nd;
        out_ready = 1'b1;
        do_start(17'h10000, 16'd0);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL z_busy got %b want 1", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL z_done_early got %b want 0", done); end
        observe(2, -1, nx, no, fi, da, nd);
        vectors += 4;
        if (da !== 1) begin miscompares++; $display("FAIL z_done_at got %0d want 1", da); end
        if (nd !== 1) begin miscompares++; $display("FAIL z_ndone got %0d want 1", nd); end
        if (nx !== 0) begin miscompares++; $display("FAIL z_xfers got %0d want 0", nx); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL z_busy_end got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int nx, no, fi, da, nd;
        do_start(17'h10000, 16'd10);
        observe(16, 2, nx, no, fi, da, nd);
        vectors += 6;
        if (nx !== 10) begin miscompares++; $display("FAIL ig_xfers got %0d want 10", nx); end
        if (no !== 10) begin miscompares++; $display("FAIL ig_ones got %0d want 10", no); end
        if (fi !== 1) begin miscompares++; $display("FAIL ig_first got %0d want 1", fi); end
        if (da !== 11) begin miscompares++; $display("FAIL ig_done_at got %0d want 11", da); end
        if (nd !== 1) begin miscompares++; $display("FAIL ig_ndone got %0d want 1", nd); end
        if (ones_count !== 16'(exp_tally(10))) begin miscompares++; $display("FAIL ig_tally got %0d want %0d", ones_count, exp_tally(10)); end
    endtask

    task automatic test_reset_midrun;
        int nx, no, fi, da, nd;
        do_start(17'h10000, 16'd10);
        observe(4, -1, nx, no, fi, da, nd);
        vectors++;
        if (nx !== 3) begin miscompares++; $display("FAIL mr_pre_xfers got %0d want 3", nx); end
        reset_n = 1'b0;
        #1;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mr_valid got %b want 0", out_valid); end
        if (out_bit !== 1'b0) begin miscompares++; $display("FAIL mr_bit got %b want 0", out_bit); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mr_busy got %b want 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL mr_done got %b want 0", done); end
        if (ones_count !== 16'd0) begin miscompares++; $display("FAIL mr_ones got %0d want 0", ones_count); end
        @(negedge clk);
        reset_n = 1'b1;
        observe(4, -1, nx, no, fi, da, nd);
        vectors += 2;
        if (nd !== 0) begin miscompares++; $display("FAIL mr_no_done got %0d want 0", nd); end
        if (nx !== 0) begin miscompares++; $display("FAIL mr_no_xfer got %0d want 0", nx); end
        do_start(17'h10000, 16'd10);
        observe(16, -1, nx, no, fi, da, nd);
        vectors += 4;
        if (nx !== 10) begin miscompares++; $display("FAIL mr_re_xfers got %0d want 10", nx); end
        if (no !== 10) begin miscompares++; $display("FAIL mr_re_ones got %0d want 10", no); end
        if (da !== 11) begin miscompares++; $display("FAIL mr_re_done_at got %0d want 11", da); end
        if (ones_count !== 16'(exp_tally(10))) begin miscompares++; $display("FAIL mr_re_tally got %0d want %0d", ones_count, exp_tally(10)); end
    endtask

    initial begin
        test_reset;
        test_prob_zero;
        test_prob_one;
        test_threshold;
        test_backpressure;
        test_zero_shots;
        test_back_to_back;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
